prio_grant_arbiter: RTL

- Sequencing arbiter that shares one resource among 8 requesters using the datapath's highest-set-bit priority: the highest request index wins.
- Grants are registered and held while the winner keeps its request asserted, bounded by a hold timeout.
- A timed-out requester is masked for the following arbitration so lower-priority requesters are served, preventing starvation.
- Sits between requester ports and the shared resource; gnt_idx drives the resource's select input.

---
 rtl/prio_grant_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/prio_grant_arbiter.sv
// prio_grant_arbiter: highest-index-wins arbiter for 8 requesters.
// A grant is held while its request stays high, up to MAX_HOLD cycles.
// A requester that hits the hold limit is masked for the next arbitration.
// All outputs come straight from flops.
module prio_grant_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       en,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic       busy_q, busy_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;

  logic [7:0] masked_s;
  logic       fallback_s;
  logic [7:0] eff_s;
  logic [2:0] winner_s;
  logic [7:0] mask_set_s;
  logic       hold_hit_s;

  // Effective request, priority pick and next-state for FSM, mask and outputs
  always_comb begin
    masked_s   = req & ~mask_q;
    fallback_s = (masked_s == 8'd0);
    eff_s      = fallback_s ? req : masked_s;
    // Ascending scan: the last (highest) set bit overwrites earlier ones.
    winner_s   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eff_s[i]) begin
        winner_s = 3'(i);
      end else begin
        winner_s = winner_s;
      end
    end
    hold_hit_s  = (hold_cnt_q == 8'(MAX_HOLD));

    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    busy_d      = busy_q;
    hold_cnt_d  = hold_cnt_q;
    mask_set_s  = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (en && (eff_s != 8'd0)) begin
          state_d     = ST_GRANT;
          gnt_d       = 8'd1 << winner_s;
          gnt_idx_d   = winner_s;
          gnt_valid_d = 1'b1;
          busy_d      = 1'b1;
          hold_cnt_d  = 8'd1;
        end else begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          hold_cnt_d  = 8'd0;
        end
      end
      ST_GRANT: begin
        // Release takes precedence over the hold limit at the same edge.
        if (!req[gnt_idx_q]) begin
          state_d     = ST_GAP;
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end else if (hold_hit_s) begin
          state_d     = ST_GAP;
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = 8'd0;
          timeout_d   = 1'b1;
          mask_set_s  = 8'd1 << gnt_idx_q;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d     = ST_IDLE;
        gnt_d       = 8'd0;
        gnt_idx_d   = 3'd0;
        gnt_valid_d = 1'b0;
        busy_d      = 1'b0;
        hold_cnt_d  = 8'd0;
      end
    endcase

    // Bits clear whenever their request is low (clear beats set); when the
    // mask would hide every request it is dropped entirely.
    if (fallback_s) begin
      mask_d = mask_set_s & req;
    end else begin
      mask_d = (mask_q | mask_set_s) & req;
    end
  end

  // State, mask, hold counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      mask_q      <= 8'd0;
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      mask_q      <= mask_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule
